// File: rtl/fifo_rd_ptr_empty.sv
// Read-side pointer and flag logic of an asynchronous FIFO: synchronises the Gray write pointer
// into the read domain and derives read address, empty, almost_empty, level and underflow.
module fifo_rd_ptr_empty #(
  parameter int unsigned ADDR_WIDTH      = 4,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned ALMOST_EMPTY_TH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH:0]   wptr_gray_async,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [ADDR_WIDTH:0]   rptr_gray,
  output logic                  empty,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   rd_level,
  output logic                  underflow
);

  localparam int unsigned PW = ADDR_WIDTH + 1;

  logic [PW-1:0] sync_d [SYNC_STAGES];
  logic [PW-1:0] sync_q [SYNC_STAGES];
  logic [PW-1:0] wsync;
  logic [PW-1:0] wbin;

  logic [PW-1:0] rbin_d, rbin_q;
  logic [PW-1:0] rgray_d, rgray_q;
  logic [PW-1:0] level_d, level_q;
  logic          empty_d, empty_q;
  logic          almost_d, almost_q;
  logic          underflow_d, underflow_q;
  logic          rd_inc;

  // Plain flop chain, no logic between stages.
  always_comb begin
    sync_d[0] = wptr_gray_async;
    for (int i = 1; i < int'(SYNC_STAGES); i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(SYNC_STAGES); i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(SYNC_STAGES); i++) begin
        sync_q[i] <= sync_d[i];
      end
    end
  end

  assign wsync = sync_q[SYNC_STAGES-1];

  // Each binary bit is the XOR of all Gray bits at and above it.
  always_comb begin
    wbin = '0;
    for (int i = 0; i < int'(PW); i++) begin
      wbin[i] = ^(wsync >> i);
    end
  end

  always_comb begin
    rd_inc      = rd_en & ~empty_q;
    rbin_d      = rbin_q + PW'(rd_inc);
    rgray_d     = rbin_d ^ (rbin_d >> 1);
    level_d     = wbin - rbin_d;
    empty_d     = (rgray_d == wsync);
    almost_d    = (32'(level_d) <= ALMOST_EMPTY_TH);
    underflow_d = rd_en & empty_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rbin_q      <= '0;
      rgray_q     <= '0;
      level_q     <= '0;
      empty_q     <= 1'b1;
      almost_q    <= 1'b1;
      underflow_q <= 1'b0;
    end else begin
      rbin_q      <= rbin_d;
      rgray_q     <= rgray_d;
      level_q     <= level_d;
      empty_q     <= empty_d;
      almost_q    <= almost_d;
      underflow_q <= underflow_d;
    end
  end

  assign rd_addr      = rbin_q[ADDR_WIDTH-1:0];
  assign rptr_gray    = rgray_q;
  assign empty        = empty_q;
  assign almost_empty = almost_q;
  assign rd_level     = level_q;
  assign underflow    = underflow_q;

endmodule
